// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller with HI/LO registers (optional madd: MDU_MADD_EN)
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MU_op,
    input  logic        Start,
    input  logic        Req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MU_result
);

    localparam int CW = 16;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd9;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [63:0]     res;
    logic            res_ok;

    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic [31:0]     quot_s;
    logic [31:0]     rem_s;
    logic [31:0]     quot_u;
    logic [31:0]     rem_u;
    logic            div_zero;
    logic            start_mul;
    logic            start_div;
    logic [63:0]     next_res;
`ifdef MDU_MADD_EN
    logic [63:0]     madd_sum;
`endif

    // Operand arithmetic; the whole result is captured at the Start edge
    always_comb begin
        prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u   = {32'd0, A} * {32'd0, B};
        div_zero = (B == 32'd0);
        if (div_zero) begin
            quot_s = 32'd0;
            rem_s  = 32'd0;
            quot_u = 32'd0;
            rem_u  = 32'd0;
        end else begin
            quot_s = $signed(A) / $signed(B);
            rem_s  = $signed(A) % $signed(B);
            quot_u = A / B;
            rem_u  = A % B;
        end
`ifdef MDU_MADD_EN
        madd_sum  = {HI, LO} + prod_s;
        start_mul = Start && (MU_op == OP_MULT || MU_op == OP_MULTU || MU_op == OP_MADD);
`else
        start_mul = Start && (MU_op == OP_MULT || MU_op == OP_MULTU);
`endif
        start_div = Start && (MU_op == OP_DIV || MU_op == OP_DIVU);
        case (MU_op)
            OP_MULT:  next_res = prod_s;
            OP_MULTU: next_res = prod_u;
            OP_DIV:   next_res = {rem_s, quot_s};
            OP_DIVU:  next_res = {rem_u, quot_u};
`ifdef MDU_MADD_EN
            OP_MADD:  next_res = madd_sum;
`endif
            default:  next_res = 64'd0;
        endcase
    end

    // Read port for mfhi/mflo; returns architectural values, so old ones while busy
    always_comb begin
        case (MU_op)
            OP_MFHI: MU_result = HI;
            OP_MFLO: MU_result = LO;
            default: MU_result = 32'd0;
        endcase
    end

    // Controller: accept operations in IDLE, count busy cycles, commit on the last one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res    <= 64'd0;
            res_ok <= 1'b0;
            Busy   <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!Req) begin
                        if (start_mul) begin
                            res    <= next_res;
                            res_ok <= 1'b1;
                            cnt    <= CW'(MUL_CYCLES);
                            state  <= MUL;
                            Busy   <= 1'b1;
                        end else if (start_div) begin
                            res    <= next_res;
                            res_ok <= !div_zero;
                            cnt    <= CW'(DIV_CYCLES);
                            state  <= DIV;
                            Busy   <= 1'b1;
                        end else if (MU_op == OP_MTHI) begin
                            HI <= A;
                        end else if (MU_op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                default: begin
                    if (cnt == CW'(1)) begin
                        if (res_ok) begin
                            HI <= res[63:32];
                            LO <= res[31:0];
                        end
                        cnt   <= '0;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - randomized self-checking bench for mdu_ctrl
module tb_mdu_ctrl;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  MU_op;
    logic        Start;
    logic        Req;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MU_result;

    int n_checks;
    int n_pass;

    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mdu_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .reset(reset), .MU_op(MU_op), .Start(Start), .Req(Req),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MU_result(MU_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: busy length and resulting HI/LO straight from the architectural rules
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit req, input bit start,
                         output int n, output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] p;
        n  = 0;
        eh = model_hi;
        el = model_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        if (!req) begin
            case (op)
                4'd0: if (start) begin p = sa * sb; {eh, el} = p; n = MULC; end
                4'd1: if (start) begin p = ua * ub; {eh, el} = p; n = MULC; end
                4'd2: if (start) begin
                    n = DIVC;
                    if (b != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
                end
                4'd3: if (start) begin
                    n = DIVC;
                    if (b != 0) begin el = 32'(ua / ub); eh = 32'(ua % ub); end
                end
                4'd4: eh = a;
                4'd5: el = a;
`ifdef MDU_MADD_EN
                4'd9: if (start) begin p = {model_hi, model_lo} + 64'(sa * sb); {eh, el} = p; n = MULC; end
`endif
                default: ;
            endcase
        end
    endtask

    // Issue one instruction, poke at the unit while it is busy, then check the commit
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit req, input bit start);
        int n;
        logic [31:0] eh, el;
        model(op, a, b, req, start, n, eh, el);
        MU_op = op; Start = start; Req = req; A = a; B = b;
        step();
        MU_op = 4'd8; Start = 1'b0; Req = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("busy_high", 64'(Busy), 64'd1);
            MU_op = 4'd6;
            #1;
            check("mfhi_old", 64'(MU_result), 64'(model_hi));
            MU_op = ($urandom_range(0, 1) != 0) ? 4'd5 : 4'd4;
            Start = 1'($urandom_range(0, 1));
            A = $urandom;
            B = $urandom;
            step();
        end
        MU_op = 4'd8; Start = 1'b0;
        check("busy_low", 64'(Busy), 64'd0);
        check("hi", 64'(HI), 64'(eh));
        check("lo", 64'(LO), 64'(el));
        model_hi = eh;
        model_lo = el;
        MU_op = 4'd6; #1;
        check("mfhi", 64'(MU_result), 64'(model_hi));
        MU_op = 4'd7; #1;
        check("mflo", 64'(MU_result), 64'(model_lo));
        MU_op = 4'd8; #1;
        check("mu_none", 64'(MU_result), 64'd0);
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] a, b;
        bit req;
        n_checks = 0;
        n_pass   = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        reset = 1'b0; MU_op = 4'd8; Start = 1'b0; Req = 1'b0; A = 32'd0; B = 32'd0;
        #22;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_op(4'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
        check("mult_hi", 64'(HI), 64'hFFFFFFFF);
        check("mult_lo", 64'(LO), 64'hFFFFFFFA);
        run_op(4'd3, 32'd7, 32'd2, 1'b0, 1'b1);
        check("divu_lo", 64'(LO), 64'd3);
        check("divu_hi", 64'(HI), 64'd1);
        run_op(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
        check("div_lo", 64'(LO), 64'hFFFFFFFD);
        check("div_hi", 64'(HI), 64'hFFFFFFFF);
        run_op(4'd4, 32'h12345678, 32'd0, 1'b0, 1'b0);
        run_op(4'd2, 32'd99, 32'd0, 1'b0, 1'b1);
        check("div0_hi", 64'(HI), 64'h12345678);
        run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        run_op(4'd5, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0);
        run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        check("multu_lo", 64'(LO), 64'd1);
        run_op(4'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        run_op(4'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
        run_op(4'd9, 32'd1, 32'd1, 1'b0, 1'b1);
`ifdef MDU_MADD_EN
        check("madd_hi", 64'(HI), 64'd1);
        check("madd_lo", 64'(LO), 64'd0);
`else
        check("madd_off_hi", 64'(HI), 64'd0);
        check("madd_off_lo", 64'(LO), 64'hFFFFFFFF);
`endif

        // Reset in the third busy cycle of a div: clears immediately, nothing commits later
        MU_op = 4'd2; Start = 1'b1; A = 32'd100; B = 32'd7;
        step();
        MU_op = 4'd8; Start = 1'b0;
        step();
        step();
        check("pre_rst_busy", 64'(Busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_busy", 64'(Busy), 64'd0);
        check("async_hi", 64'(HI), 64'd0);
        check("async_lo", 64'(LO), 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        run_op(4'd0, 32'd6, 32'hFFFFFFFF, 1'b0, 1'b1);

        // Randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 7))
                0: op = 4'd0;
                1: op = 4'd1;
                2: op = 4'd2;
                3: op = 4'd3;
                4: op = 4'd4;
                5: op = 4'd5;
                6: op = 4'd9;
                default: op = 4'(10 + $urandom_range(0, 5));
            endcase
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            req = ($urandom_range(0, 4) == 0);
            run_op(op, a, b, req, (op != 4'd4 && op != 4'd5));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
